// File: rtl/pcap_replay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcap_replay_pkg                                                      |
// | Shared state encoding and default widths for the pcap replay gate.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pcap_replay_pkg;

  localparam int c_state_w = 2;
  typedef logic [c_state_w-1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam int c_delay_lsb_default   = 32;
  localparam int c_delay_width_default = 32;
  localparam int c_cnt_width_default   = 32;

endpackage
`default_nettype wire

// File: rtl/pcap_delay_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcap_delay_counter                                                   |
// | Loadable down-counter; expire is high while the count equals one.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pcap_delay_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pcap_replay_delay_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcap_replay_delay_gate                                               |
// | Holds each replayed packet until the tuser inter-packet gap elapses. |
// | Optional stats ports: define PCAP_DELAY_GATE_STATS_EN.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pcap_replay_delay_gate
  import pcap_replay_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DELAY_LSB          = c_delay_lsb_default,
  parameter int DELAY_WIDTH        = c_delay_width_default,
  parameter int CNT_WIDTH          = c_cnt_width_default
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            bypass_delay,
  input  logic                            sw_rst,
  output logic [CNT_WIDTH-1:0]            pkt_count
`ifdef PCAP_DELAY_GATE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]            wait_cycles,
  output logic [CNT_WIDTH-1:0]            stall_cycles
`endif
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DELAY_WIDTH-1:0] w_delay;
  logic                   w_delay_zero;
  logic                   w_open_raw;
  logic                   w_open;
  logic                   w_hs;
  logic                   w_load;
  logic                   w_dec;
  logic                   w_expire;
  logic [CNT_WIDTH-1:0]   r_pkt_count;

  assign w_delay      = bypass_delay ? '0 : s_axis_tuser[DELAY_LSB +: DELAY_WIDTH];
  assign w_delay_zero = (w_delay == '0);

  // The final WAIT cycle already opens, so the first beat lands exactly D cycles after it was seen.
  always_comb begin
    w_open_raw = 1'b0;
    case (r_state)
      ST_IDLE: w_open_raw = w_delay_zero;
      ST_WAIT: w_open_raw = w_expire;
      ST_SEND: w_open_raw = 1'b1;
      default: w_open_raw = 1'b0;
    endcase
  end

  assign w_open = w_open_raw & ~axi_areset & ~sw_rst;
  assign w_hs   = s_axis_tvalid & m_axis_tready & w_open;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & w_open;
  assign s_axis_tready = m_axis_tready & w_open;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          if (!w_delay_zero) begin
            w_next_state = ST_WAIT;
          end else if (w_hs && !s_axis_tlast) begin
            w_next_state = ST_SEND;
          end
        end
      end
      ST_WAIT: begin
        if (w_expire) begin
          w_next_state = (w_hs && s_axis_tlast) ? ST_IDLE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_hs && s_axis_tlast) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_load = (r_state == ST_IDLE) & s_axis_tvalid & ~w_delay_zero;
  assign w_dec  = (r_state == ST_WAIT);

  pcap_delay_counter #(
    .WIDTH (DELAY_WIDTH)
  ) u_delay_counter (
    .clk        (axi_aclk),
    .rst        (axi_areset),
    .i_clr      (sw_rst),
    .i_load     (w_load),
    .i_load_val (w_delay),
    .i_dec      (w_dec),
    .o_expire   (w_expire)
  );

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state     <= ST_IDLE;
      r_pkt_count <= '0;
    end else if (sw_rst) begin
      r_state     <= ST_IDLE;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_hs && s_axis_tlast) begin
        r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_count = r_pkt_count;

`ifdef PCAP_DELAY_GATE_STATS_EN
  logic [CNT_WIDTH-1:0] r_wait_cycles;
  logic [CNT_WIDTH-1:0] r_stall_cycles;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wait_cycles  <= '0;
      r_stall_cycles <= '0;
    end else if (sw_rst) begin
      r_wait_cycles  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if ((r_state == ST_WAIT) && (r_wait_cycles != '1)) begin
        r_wait_cycles <= r_wait_cycles + CNT_WIDTH'(1);
      end
      if ((r_state == ST_SEND) && m_axis_tvalid && !m_axis_tready && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

  assign wait_cycles  = r_wait_cycles;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcap_replay_delay_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pcap_replay_delay_gate                                            |
// | Directed stimulus with a queue-based scoreboard on the output port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pcap_replay_delay_gate;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         bypass;
  logic         sw_rst;
  logic [31:0]  pkt_count;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [255:0] data;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t q[$];

  pcap_replay_delay_gate dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .bypass_delay  (bypass),
    .sw_rst        (sw_rst),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && !sw_rst && m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
      end else begin
        e = q.pop_front();
        check("beat_data", m_tdata, e.data);
        check("beat_last", {255'd0, m_tlast}, {255'd0, e.last});
        check("beat_strb_user", {m_tstrb, m_tuser}, {s_tstrb, s_tuser});
        if (e.cyc >= 0) check("release_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  task automatic wait_hs();
    int n = 0;
    forever begin
      @(negedge clk);
      if (s_tvalid && s_tready) break;
      n++;
      if (n > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL handshake_timeout: got no handshake expected one within 3000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the packet is first seen in the current cycle.
  task automatic send_pkt(input int nb, input int d, input logic [7:0] tag, input bit timed);
    int seen;
    int d_eff;
    logic [255:0] dat;
    seen  = cyc;
    d_eff = bypass ? 0 : d;
    for (int i = 0; i < nb; i++) begin
      dat         = '0;
      dat[15:0]   = {tag, 8'(i)};
      s_tdata     = dat;
      s_tstrb     = {24'd0, tag};
      s_tuser     = '0;
      s_tuser[7:0] = tag;
      s_tuser[63:32] = (i == 0) ? 32'(d) : 32'd7;
      s_tlast     = (i == nb - 1);
      s_tvalid    = 1'b1;
      q.push_back('{dat, (i == nb - 1), timed ? (seen + d_eff + i) : -1});
      wait_hs();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    sw_rst   = 1'b0;
    bypass   = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_tvalid", {255'd0, m_tvalid}, 256'd0);
    check("reset_s_tready", {255'd0, s_tready}, 256'd0);
    check("reset_pkt_count", 256'(pkt_count), 256'd0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_pkt(4, 0, 8'h10, 1'b1);
    check("pkt_count_d0", 256'(pkt_count), 256'd1);

    repeat (2) @(posedge clk); #1;
    send_pkt(3, 10, 8'h20, 1'b1);
    check("pkt_count_d10", 256'(pkt_count), 256'd2);

    repeat (2) @(posedge clk); #1;
    send_pkt(2, 5, 8'h30, 1'b1);
    send_pkt(3, 3, 8'h31, 1'b1);
    check("pkt_count_b2b", 256'(pkt_count), 256'd4);

    bypass = 1'b1;
    send_pkt(2, 1000, 8'h40, 1'b1);
    bypass = 1'b0;
    send_pkt(2, 1000, 8'h41, 1'b1);
    check("pkt_count_bypass", 256'(pkt_count), 256'd6);

    fork
      send_pkt(4, 2, 8'h50, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    check("pkt_count_stall", 256'(pkt_count), 256'd7);

    @(posedge clk); #1;
    sw_rst   = 1'b1;
    s_tuser  = '0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    check("swrst_s_tready", {255'd0, s_tready}, 256'd0);
    check("swrst_m_tvalid", {255'd0, m_tvalid}, 256'd0);
    @(posedge clk); #1;
    check("swrst_pkt_count", 256'(pkt_count), 256'd0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    sw_rst   = 1'b0;

    // Hold a D=20 packet in WAIT until the counter reads 4, then hit the async reset.
    @(posedge clk); #1;
    s_tdata        = '0;
    s_tdata[15:0]  = 16'h6000;
    s_tuser        = '0;
    s_tuser[63:32] = 32'd20;
    s_tvalid       = 1'b1;
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset_m_tvalid", {255'd0, m_tvalid}, 256'd0);
    check("areset_pkt_count", 256'(pkt_count), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_pkt(2, 20, 8'h60, 1'b1);
    check("pkt_count_regate", 256'(pkt_count), 256'd1);

    repeat (5) @(posedge clk);
    check("queue_drained", 256'(q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
